branch_predict_unit: RTL and testbench

- Parametrised successor to the combinational branch comparator.
- Resolves all six RV32I/RV64I branch conditions at configurable XLEN.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters, with a sequential table-initialisation FSM and mispredict detection.
- Sits between fetch (prediction lookup) and execute (resolution/update) in the planned pipelined core.

---
 rtl/branch_predict_unit.sv | 139 +++++++++++++
 tb/tb_branch_predict_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a PC-indexed table of 2-bit saturating counters, initialised by a small FSM.
// Optional statistics counters are enabled with the BPU_STATS_EN macro.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_LSB   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            res_pred_taken,
    output logic            branch_taken,
    output logic            mispredict,
    output logic            ready,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_ENTRIES - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] init_idx;
    logic [1:0]       bht [BHT_ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             cond_legal;
    logic             cond_true;
    logic             valid_resolve;
    logic [1:0]       cur_ctr;
    logic [1:0]       next_ctr;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[INDEX_LSB +: IDX_W];
    assign res_idx  = res_pc[INDEX_LSB +: IDX_W];

    // Bits outside the index field are deliberately ignored (aliasing allowed).
    assign unused_pc_bits = ^{pred_pc, res_pc};

    always_comb begin
        cond_legal = 1'b1;
        cond_true  = 1'b0;
        case (funct3)
            3'b000:  cond_true = (rs1 == rs2);
            3'b001:  cond_true = (rs1 != rs2);
            3'b100:  cond_true = ($signed(rs1) <  $signed(rs2));
            3'b101:  cond_true = ($signed(rs1) >= $signed(rs2));
            3'b110:  cond_true = (rs1 <  rs2);
            3'b111:  cond_true = (rs1 >= rs2);
            default: cond_legal = 1'b0;
        endcase
    end

    assign branch_taken  = cond_true;
    assign valid_resolve = res_valid & cond_legal & ready;
    assign mispredict    = valid_resolve & (branch_taken != res_pred_taken);

    // Read is asynchronous, so a same-cycle update is seen only after the edge.
    assign pred_taken = ready & bht[pred_idx][1];

    always_comb begin
        cur_ctr  = bht[res_idx];
        next_ctr = cur_ctr;
        if (branch_taken) begin
            if (cur_ctr != 2'b11) begin
                next_ctr = cur_ctr + 2'b01;
            end
        end else if (cur_ctr != 2'b00) begin
            next_ctr = cur_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_idx == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        init_idx <= init_idx + IDX_W'(1);
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Single write port: initialisation sweep while in INIT, training while in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                bht[init_idx] <= 2'b01;
            end else if (valid_resolve) begin
                bht[res_idx] <= next_ctr;
            end
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (valid_resolve) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expectations, a negedge monitor drains them.
module tb_branch_predict_unit;

    localparam int SIG_PRED  = 0;
    localparam int SIG_BT    = 1;
    localparam int SIG_MP    = 2;
    localparam int SIG_READY = 3;
    localparam int SIG_STATB = 4;
    localparam int SIG_STATM = 5;

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic        res_pred_taken;
    logic        branch_taken;
    logic        mispredict;
    logic        ready;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    exp_t        sbq[$];
    exp_t        cur;
    logic [31:0] act;
    int          errors;
    int          checks;

    logic [8:0]  seq_tk;
    logic [8:0]  seq_rpt;
    logic [8:0]  seq_pred;
    logic [8:0]  seq_mp;
    logic [9:0]  st_rpt;
    logic [9:0]  st_mp;

    branch_predict_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .rs1              (rs1),
        .rs2              (rs2),
        .funct3           (funct3),
        .res_pred_taken   (res_pred_taken),
        .branch_taken     (branch_taken),
        .mispredict       (mispredict),
        .ready            (ready),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every mid-cycle, compare all expectations queued for this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            case (cur.sig)
                SIG_PRED:  act = {31'd0, pred_taken};
                SIG_BT:    act = {31'd0, branch_taken};
                SIG_MP:    act = {31'd0, mispredict};
                SIG_READY: act = {31'd0, ready};
                SIG_STATB: act = stat_branches;
                default:   act = stat_mispredicts;
            endcase
            checks = checks + 1;
            if (act !== cur.exp) begin
                errors = errors + 1;
                $display("[TB] FAIL %s: actual=%0h required=%0h", cur.name, act, cur.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] rpc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] f3, input logic rpt,
                                 input logic [31:0] ppc);
        res_valid      = v;
        res_pc         = rpc;
        rs1            = a;
        rs2            = b;
        funct3         = f3;
        res_pred_taken = rpt;
        pred_pc        = ppc;
    endtask

    task automatic idle(input logic [31:0] ppc);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, F_BEQ, 1'b0, ppc);
    endtask

    task automatic checkOutput(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle(32'h40);
        tick();
        tick();
        checkOutput("reset_ready", SIG_READY, 32'd0);
        checkOutput("reset_pred", SIG_PRED, 32'd0);
        checkOutput("reset_stat_b", SIG_STATB, 32'd0);
        checkOutput("reset_stat_m", SIG_STATM, 32'd0);
        rst = 1'b0;

        // Initialisation sweep; resolves mid-INIT must neither update nor flag.
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (k >= 20 && k <= 30) begin
                applyStimulus(1'b1, 32'h40, 32'd1, 32'd2, F_BNE, 1'b0, 32'h40);
                checkOutput($sformatf("init_mp_%0d", k), SIG_MP, 32'd0);
            end else begin
                idle(32'h40);
            end
            checkOutput($sformatf("init_ready_%0d", k), SIG_READY, 32'd0);
        end
        tick();
        idle(32'h0);
        checkOutput("ready_after_64", SIG_READY, 32'd1);
        tick();

        for (int e = 0; e < 64; e++) begin
            idle(32'(e * 4));
            checkOutput($sformatf("entry_pred_%0d", e), SIG_PRED, 32'd0);
            tick();
        end

        applyStimulus(1'b0, 32'h0, 32'd5, 32'd5, F_BEQ, 1'b0, 32'h0);
        checkOutput("beq_eq", SIG_BT, 32'd1);
        checkOutput("beq_no_valid_mp", SIG_MP, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'd5, 32'd5, F_BNE, 1'b0, 32'h0);
        checkOutput("bne_eq", SIG_BT, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, F_BLT, 1'b0, 32'h0);
        checkOutput("blt_signed", SIG_BT, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, F_BLTU, 1'b0, 32'h0);
        checkOutput("bltu_unsigned", SIG_BT, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'd1, 32'hFFFF_FFFF, F_BGE, 1'b0, 32'h0);
        checkOutput("bge_signed", SIG_BT, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, F_BGEU, 1'b0, 32'h0);
        checkOutput("bgeu_unsigned", SIG_BT, 32'd1);
        tick();
        applyStimulus(1'b1, 32'h40, 32'd5, 32'd5, 3'b010, 1'b1, 32'h40);
        checkOutput("f010_bt", SIG_BT, 32'd0);
        checkOutput("f010_mp", SIG_MP, 32'd0);
        tick();
        applyStimulus(1'b1, 32'h40, 32'd5, 32'd5, 3'b011, 1'b1, 32'h40);
        checkOutput("f011_bt", SIG_BT, 32'd0);
        checkOutput("f011_mp", SIG_MP, 32'd0);
        tick();

        // Counter walk at 0x40: 01 ->10 ->11 ->11 ->10 ->01 ->00 ->00 ->01 ->10.
        seq_tk   = 9'b110000111;
        seq_rpt  = 9'b000011110;
        seq_pred = 9'b000011110;
        seq_mp   = 9'b110011001;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 32'h40, 32'd1, seq_tk[i] ? 32'd2 : 32'd1, F_BNE, seq_rpt[i], 32'h40);
            checkOutput($sformatf("walk_bt_%0d", i), SIG_BT, {31'd0, seq_tk[i]});
            checkOutput($sformatf("walk_pred_%0d", i), SIG_PRED, {31'd0, seq_pred[i]});
            checkOutput($sformatf("walk_mp_%0d", i), SIG_MP, {31'd0, seq_mp[i]});
            tick();
        end
        idle(32'h40);
        checkOutput("walk_final_pred", SIG_PRED, 32'd1);
        tick();

        applyStimulus(1'b1, 32'h80, 32'd3, 32'd3, F_BEQ, 1'b0, 32'h80);
        checkOutput("same_cycle_pred", SIG_PRED, 32'd0);
        checkOutput("same_cycle_mp", SIG_MP, 32'd1);
        tick();
        idle(32'h180);
        checkOutput("alias_0x180_pred", SIG_PRED, 32'd1);
        tick();
        idle(32'h80);
        checkOutput("next_cycle_0x80_pred", SIG_PRED, 32'd1);
        tick();
        idle(32'h84);
        checkOutput("neighbour_0x84_pred", SIG_PRED, 32'd0);
        tick();

        // Reset from RUN, then again part-way through INIT at index 20.
        rst = 1'b1;
        idle(32'h40);
        tick();
        checkOutput("midrun_rst_ready", SIG_READY, 32'd0);
        checkOutput("midrun_rst_pred", SIG_PRED, 32'd0);
        checkOutput("midrun_rst_stat_b", SIG_STATB, 32'd0);
        checkOutput("midrun_rst_stat_m", SIG_STATM, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkOutput($sformatf("reinit_ready_%0d", k), SIG_READY, 32'd0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (k >= 5 && k <= 10) begin
                applyStimulus(1'b1, 32'h40, 32'd1, 32'd2, F_BNE, 1'b0, 32'h40);
                checkOutput($sformatf("reinit2_mp_%0d", k), SIG_MP, 32'd0);
            end else begin
                idle(32'h40);
            end
            checkOutput($sformatf("reinit2_ready_%0d", k), SIG_READY, 32'd0);
        end
        tick();
        idle(32'h40);
        checkOutput("reinit2_ready_64", SIG_READY, 32'd1);
        checkOutput("reinit2_pred_0x40", SIG_PRED, 32'd0);
        tick();
        idle(32'h80);
        checkOutput("reinit2_pred_0x80", SIG_PRED, 32'd0);
        tick();

        // Statistics: 10 valid resolves (3 mispredicts) plus 2 illegal ones.
        st_rpt = 10'b1011011011;
        st_mp  = 10'b0100100100;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i * 8), 32'd7, 32'd7, F_BEQ, st_rpt[i], 32'h0);
            checkOutput($sformatf("stat_mp_%0d", i), SIG_MP, {31'd0, st_mp[i]});
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h10, 32'd7, 32'd7, 3'b011, 1'b0, 32'h0);
            checkOutput($sformatf("stat_illegal_mp_%0d", i), SIG_MP, 32'd0);
            tick();
        end
        idle(32'h0);
`ifdef BPU_STATS_EN
        checkOutput("stat_branches", SIG_STATB, 32'd10);
        checkOutput("stat_mispredicts", SIG_STATM, 32'd3);
`else
        checkOutput("stat_branches_off", SIG_STATB, 32'd0);
        checkOutput("stat_mispredicts_off", SIG_STATM, 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        checkOutput("final_rst_stat_b", SIG_STATB, 32'd0);
        checkOutput("final_rst_stat_m", SIG_STATM, 32'd0);
        checkOutput("final_rst_ready", SIG_READY, 32'd0);
        rst = 1'b0;
        tick();

        for (int w = 0; w < 5 && sbq.size() > 0; w++) begin
            @(negedge clk);
        end
        #1;
        if (sbq.size() != 0) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("[TB] FAIL drain: actual=%0d pending required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
